// File: rtl/dsp_pipeline_sequencer_pkg.sv
// Shared encodings for the DSP pipeline sequencer: sequencer states,
// operating modes and a helper for sizing the channel field.
package dsp_pipeline_sequencer_pkg;

  // Sequencer control states.
  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_ISSUE = 3'd1,
    SEQ_GUARD = 3'd2,
    SEQ_WAIT  = 3'd3,
    SEQ_EMIT  = 3'd4,
    SEQ_FAULT = 3'd5
  } seq_state_e;

  // Operating modes; the reserved code behaves like process.
  typedef enum logic [1:0] {
    SEQ_MODE_PROCESS  = 2'd0,
    SEQ_MODE_BYPASS   = 2'd1,
    SEQ_MODE_MUTE     = 2'd2,
    SEQ_MODE_RESERVED = 2'd3
  } seq_mode_e;

  // Channel index width; a single-channel build still carries one bit.
  function automatic int ch_bits(input int n_channels);
    return (n_channels > 1) ? $clog2(n_channels) : 1;
  endfunction

endpackage

// File: rtl/dsp_pipeline_sequencer_seq_fifo.sv
// Small synchronous show-ahead FIFO with flush, full/empty and occupancy.
// A push is accepted when not full, or when full with a simultaneous pop.
module dsp_pipeline_sequencer_seq_fifo #(
  parameter int width = 17,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [width-1:0]           wdata,
  input  logic                       pop,
  output logic [width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(depth):0]     count
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == cw'(depth));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything including a same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are meaningful, so clearing the data would only cost logic.
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dsp_pipeline_sequencer.sv
// Sample sequencer between the audio front end and dsp_core. Buffers
// channel-tagged samples, ticks the core once per sample (or bypasses /
// mutes it), guards completion with a watchdog and keeps statistics.
module dsp_pipeline_sequencer
  import dsp_pipeline_sequencer_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int n_channels     = 2,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 4096,
  parameter int ctr_width      = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [data_width-1:0]              in_sample,
  input  logic [ch_bits(n_channels)-1:0]     in_channel,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [1:0]                         mode,
  input  logic                               clear_error,
  output logic                               core_tick,
  output logic [data_width-1:0]              core_sample_in,
  output logic [ch_bits(n_channels)-1:0]     core_channel,
  input  logic                               core_ready,
  input  logic [data_width-1:0]              core_sample_out,
  output logic [data_width-1:0]              out_sample,
  output logic [ch_bits(n_channels)-1:0]     out_channel,
  output logic                               out_valid,
  output logic                               busy,
  output logic                               error,
  output logic [ctr_width-1:0]               samples_processed,
  output logic [ctr_width-1:0]               overruns
);

  localparam int ch_w = ch_bits(n_channels);
  localparam int wd_w = $clog2(timeout_cycles + 1);
  localparam int fw   = data_width + ch_w;

  localparam logic [ch_w:0] n_ch_lim = (ch_w + 1)'(n_channels);

  typedef struct packed {
    logic [ch_w-1:0]       ch;
    logic [data_width-1:0] s;
  } entry_t;

  seq_state_e state_q, state_d;

  entry_t                  in_entry;
  entry_t                  head;
  logic [fw-1:0]           fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(fifo_depth):0] fifo_count;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_flush;

  logic                    latch_in;
  logic                    wd_load;
  logic                    wd_dec;
  logic                    load_out;
  logic                    count_sample;
  logic [data_width-1:0]   out_sample_d;
  logic [ch_w-1:0]         out_channel_d;

  logic [data_width-1:0]   smp_q;
  logic [ch_w-1:0]         ch_q;
  logic [wd_w-1:0]         wd_q;
  logic [data_width-1:0]   out_sample_q;
  logic [ch_w-1:0]         out_channel_q;
  logic [ctr_width-1:0]    samples_q;
  logic [ctr_width-1:0]    overruns_q;

  // Out-of-range channel indices are folded onto channel 0 before buffering.
  always_comb begin
    in_entry.s  = in_sample;
    in_entry.ch = ({1'b0, in_channel} >= n_ch_lim) ? '0 : in_channel;
  end

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign head      = entry_t'(fifo_rdata);

  dsp_pipeline_sequencer_seq_fifo #(
    .width (fw),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wdata   (in_entry),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEQ_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    fifo_pop      = 1'b0;
    fifo_flush    = 1'b0;
    latch_in      = 1'b0;
    wd_load       = 1'b0;
    wd_dec        = 1'b0;
    load_out      = 1'b0;
    count_sample  = 1'b0;
    out_sample_d  = '0;
    out_channel_d = '0;

    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          latch_in = 1'b1;
          case (seq_mode_e'(mode))
            SEQ_MODE_BYPASS: begin
              load_out      = 1'b1;
              out_sample_d  = head.s;
              out_channel_d = head.ch;
              state_d       = SEQ_EMIT;
            end
            SEQ_MODE_MUTE: begin
              load_out      = 1'b1;
              out_sample_d  = '0;
              out_channel_d = head.ch;
              state_d       = SEQ_EMIT;
            end
            default: state_d = SEQ_ISSUE;
          endcase
        end
      end
      SEQ_ISSUE: begin
        wd_load = 1'b1;
        state_d = SEQ_GUARD;
      end
      // The core drops core_ready one cycle after a tick; skip that cycle.
      SEQ_GUARD: state_d = SEQ_WAIT;
      SEQ_WAIT: begin
        wd_dec = (wd_q != '0);
        if (core_ready) begin
          load_out      = 1'b1;
          out_sample_d  = core_sample_out;
          out_channel_d = ch_q;
          state_d       = SEQ_EMIT;
        end else if (wd_q <= wd_w'(1)) begin
          state_d = SEQ_FAULT;
        end
      end
      SEQ_EMIT: begin
        count_sample = 1'b1;
        state_d      = SEQ_IDLE;
      end
      SEQ_FAULT: begin
        if (clear_error) begin
          fifo_flush = 1'b1;
          state_d    = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_FAULT;
    endcase
  end

  // Sample latch, watchdog, result hold registers and saturating statistics.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_q         <= '0;
      ch_q          <= '0;
      wd_q          <= '0;
      out_sample_q  <= '0;
      out_channel_q <= '0;
      samples_q     <= '0;
      overruns_q    <= '0;
    end else begin
      if (latch_in) begin
        smp_q <= head.s;
        ch_q  <= head.ch;
      end
      if (wd_load)     wd_q <= wd_w'(timeout_cycles);
      else if (wd_dec) wd_q <= wd_q - 1'b1;
      if (load_out) begin
        out_sample_q  <= out_sample_d;
        out_channel_q <= out_channel_d;
      end
      if (count_sample && (samples_q != '1)) samples_q <= samples_q + 1'b1;
      if (in_valid && !in_ready && (overruns_q != '1)) overruns_q <= overruns_q + 1'b1;
    end
  end

  assign core_tick         = (state_q == SEQ_ISSUE);
  assign core_sample_in    = smp_q;
  assign core_channel      = ch_q;
  assign out_valid         = (state_q == SEQ_EMIT);
  assign out_sample        = out_sample_q;
  assign out_channel       = out_channel_q;
  assign error             = (state_q == SEQ_FAULT);
  assign busy              = (state_q != SEQ_IDLE) || (fifo_count != '0);
  assign samples_processed = samples_q;
  assign overruns          = overruns_q;

endmodule

// File: tb/tb_dsp_pipeline_sequencer.sv
// Directed bench for dsp_pipeline_sequencer with a 3-cycle doubling core
// model and a scoreboard of expected output samples.
module tb_dsp_pipeline_sequencer;

  localparam int DW    = 16;
  localparam int NCH   = 3;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int CW    = 32;
  localparam int CHW   = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [DW-1:0]   in_sample = '0;
  logic [CHW-1:0]  in_channel = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      mode = 2'd0;
  logic            clear_error = 1'b0;
  logic            core_tick;
  logic [DW-1:0]   core_sample_in;
  logic [CHW-1:0]  core_channel;
  logic            core_ready;
  logic [DW-1:0]   core_sample_out;
  logic [DW-1:0]   out_sample;
  logic [CHW-1:0]  out_channel;
  logic            out_valid;
  logic            busy;
  logic            error;
  logic [CW-1:0]   samples_processed;
  logic [CW-1:0]   overruns;

  typedef struct {
    logic [DW-1:0]  s;
    logic [CHW-1:0] ch;
    int             cyc;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   ticks = 0;
  int   n_expected = 0;
  int   last_push_cyc = 0;
  bit   core_hold = 1'b0;
  bit   core_busy;
  int   core_cnt;
  logic [DW-1:0] core_res;

  dsp_pipeline_sequencer #(
    .data_width     (DW),
    .n_channels     (NCH),
    .fifo_depth     (DEPTH),
    .timeout_cycles (TO),
    .ctr_width      (CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_sample         (in_sample),
    .in_channel        (in_channel),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mode              (mode),
    .clear_error       (clear_error),
    .core_tick         (core_tick),
    .core_sample_in    (core_sample_in),
    .core_channel      (core_channel),
    .core_ready        (core_ready),
    .core_sample_out   (core_sample_out),
    .out_sample        (out_sample),
    .out_channel       (out_channel),
    .out_valid         (out_valid),
    .busy              (busy),
    .error             (error),
    .samples_processed (samples_processed),
    .overruns          (overruns)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Core model: ready drops on the edge that sees a tick, returns 3 cycles later with in*2.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready      <= 1'b1;
      core_busy       <= 1'b0;
      core_cnt        <= 0;
      core_res        <= '0;
      core_sample_out <= '0;
    end else if (core_tick) begin
      core_ready <= 1'b0;
      core_busy  <= 1'b1;
      core_cnt   <= 2;
      core_res   <= core_sample_in << 1;
    end else if (core_busy) begin
      if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
      end else if (!core_hold) begin
        core_ready      <= 1'b1;
        core_busy       <= 1'b0;
        core_sample_out <= core_res;
      end
    end
  end

  always @(negedge clk) if (core_tick) ticks++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("out_sample", 64'(out_sample), 64'(mon_e.s));
        check("out_channel", 64'(out_channel), 64'(mon_e.ch));
        if (mon_e.lat >= 0) check("latency", 64'(cyc - mon_e.cyc), 64'(mon_e.lat));
      end
    end
  end

  task automatic push(input logic [DW-1:0] s, input logic [CHW-1:0] ch, input bit expect_out,
                      input logic [DW-1:0] es, input logic [CHW-1:0] ech, input int lat);
    @(negedge clk);
    in_sample     = s;
    in_channel    = ch;
    in_valid      = 1'b1;
    last_push_cyc = cyc;
    if (expect_out) begin
      exp_q.push_back('{s: es, ch: ech, cyc: cyc, lat: lat});
      n_expected++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_processed"}, 64'(samples_processed), 64'(n_expected));
  endtask

  initial begin
    int t0;
    int c0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_core_tick", 64'(core_tick), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_processed", 64'(samples_processed), 64'(0));
    check("rst_overruns", 64'(overruns), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Process mode, single sample
    t0 = ticks;
    mode = 2'd0;
    push(16'h0100, 2'd1, 1'b1, 16'h0200, 2'd1, 7);
    wait_idle("proc");
    check("proc_ticks", 64'(ticks - t0), 64'(1));

    // Burst of six with the core stalled: five accepted, one dropped
    core_hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_sample  = 16'h1000 + 16'(i);
      in_channel = 2'(i % 3);
      in_valid   = 1'b1;
      if (i == 0) check("burst_ready_first", 64'(in_ready), 64'(1));
      if (i == 5) check("burst_ready_full", 64'(in_ready), 64'(0));
      if (i < 5) begin
        exp_q.push_back('{s: 16'h2000 + 16'(2 * i), ch: 2'(i % 3), cyc: cyc, lat: -1});
        n_expected++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("burst_overruns", 64'(overruns), 64'(1));
    repeat (2) @(negedge clk);
    core_hold = 1'b0;
    wait_idle("burst");

    // Bypass then mute: no core ticks
    t0 = ticks;
    mode = 2'd1;
    push(16'h7FFF, 2'd2, 1'b1, 16'h7FFF, 2'd2, 2);
    wait_idle("bypass");
    mode = 2'd2;
    push(16'h1234, 2'd1, 1'b1, 16'h0000, 2'd1, 2);
    wait_idle("mute");
    // Out-of-range channel is folded to 0
    mode = 2'd1;
    push(16'h5555, 2'd3, 1'b1, 16'h5555, 2'd0, 2);
    wait_idle("chan_fold");
    check("bypass_mute_ticks", 64'(ticks - t0), 64'(0));

    // Reserved mode behaves as process
    t0 = ticks;
    mode = 2'd3;
    push(16'h0011, 2'd1, 1'b1, 16'h0022, 2'd1, 7);
    wait_idle("reserved");
    check("reserved_ticks", 64'(ticks - t0), 64'(1));

    // Watchdog: core never completes
    mode = 2'd0;
    core_hold = 1'b1;
    push(16'h0042, 2'd1, 1'b0, 16'h0000, 2'd0, -1);
    c0 = last_push_cyc;
    for (int i = 0; i < 40; i++) begin
      if (error) break;
      @(negedge clk);
    end
    check("wd_fault_cycle", 64'(cyc - c0), 64'(20));
    check("wd_error", 64'(error), 64'(1));
    check("wd_fault_ready", 64'(in_ready), 64'(1));
    push(16'h0099, 2'd0, 1'b0, 16'h0000, 2'd0, -1);
    check("wd_fault_busy", 64'(busy), 64'(1));
    t0 = ticks;
    @(negedge clk);
    clear_error = 1'b1;
    @(negedge clk);
    clear_error = 1'b0;
    check("clr_error", 64'(error), 64'(0));
    check("clr_flushed", 64'(busy), 64'(0));
    check("fault_no_tick", 64'(ticks - t0), 64'(0));
    core_hold = 1'b0;
    repeat (2) @(negedge clk);
    push(16'h0003, 2'd2, 1'b1, 16'h0006, 2'd2, 7);
    wait_idle("post_clear");

    // Mode switched to bypass during WAIT
    t0 = ticks;
    mode = 2'd0;
    push(16'h0101, 2'd1, 1'b1, 16'h0202, 2'd1, 7);
    repeat (3) @(negedge clk);
    mode = 2'd1;
    push(16'h0BEE, 2'd0, 1'b1, 16'h0BEE, 2'd0, -1);
    wait_idle("mode_switch");
    check("mode_switch_ticks", 64'(ticks - t0), 64'(1));

    // Reset asserted mid-WAIT with two queued entries
    mode = 2'd0;
    core_hold = 1'b1;
    push(16'h0077, 2'd1, 1'b0, 16'h0000, 2'd0, -1);
    repeat (3) @(negedge clk);
    push(16'h0078, 2'd0, 1'b0, 16'h0000, 2'd0, -1);
    push(16'h0079, 2'd2, 1'b0, 16'h0000, 2'd0, -1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_sample", 64'(out_sample), 64'(0));
    check("mid_rst_out_channel", 64'(out_channel), 64'(0));
    check("mid_rst_core_sample", 64'(core_sample_in), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_processed", 64'(samples_processed), 64'(0));
    check("mid_rst_overruns", 64'(overruns), 64'(0));
    n_expected = 0;
    core_hold = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    t0 = ticks;
    repeat (10) @(negedge clk);
    check("post_rst_no_tick", 64'(ticks - t0), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));
    push(16'h0010, 2'd1, 1'b1, 16'h0020, 2'd1, 7);
    wait_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
